// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor (diff = a ^ b ^ borrow_in) built purely from NOR gates,
// mirroring the structure of the NOR full-adder cell.
module subtractor_cell
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic n1, aNotB, bNotA, abXnor, abXor;
  logic m1, m2, m3;
  logic borrowInN, propBorrow, borrowOr;

  // First XNOR stage; bNotA doubles as the generate term (~a & b).
  nor g1 (n1, a, b);
  nor g2 (bNotA, a, n1);
  nor g3 (aNotB, b, n1);
  nor g4 (abXnor, bNotA, aNotB);
  nor g5 (abXor, abXnor, abXnor);

  // XNOR of (a xnor b) with borrow_in equals a ^ b ^ borrow_in.
  nor g6 (m1, abXnor, borrow_in);
  nor g7 (m2, abXnor, m1);
  nor g8 (m3, borrow_in, m1);
  nor g9 (diff, m2, m3);

  // Borrow propagates when the operand bits match: (a xnor b) & borrow_in.
  nor g10 (borrowInN, borrow_in, borrow_in);
  nor g11 (propBorrow, abXor, borrowInN);
  nor g12 (borrowOr, bNotA, propBorrow);
  nor g13 (borrow_out, borrowOr, borrowOr);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b over WIDTH cycles with a
// start/busy/done handshake and registered result, borrow and zero flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] resShift_q;
  logic             borrow_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             borrowOut_q;
  logic             zero_q;

  logic             diffBit;
  logic             borrow_d;
  logic [WIDTH-1:0] resShift_d;
  logic             lastBit;

  subtractor_cell uCell (
    .a          (aShift_q[0]),
    .b          (bShift_q[0]),
    .borrow_in  (borrow_q),
    .diff       (diffBit),
    .borrow_out (borrow_d)
  );

  always_comb begin
    resShift_d = {diffBit, resShift_q[WIDTH-1:1]};
    lastBit    = (count_q == LAST_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      resShift_q  <= '0;
      borrow_q    <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      borrowOut_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            aShift_q <= a;
            bShift_q <= b;
            borrow_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end

        RUN: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          resShift_q <= resShift_d;
          borrow_q   <= borrow_d;
          count_q    <= count_q + CNT_W'(1);
          if (lastBit) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= resShift_d;
            borrowOut_q <= borrow_d;
            zero_q      <= (resShift_d == '0);
            state_q     <= DONE;
          end
        end

        // The edge leaving DONE may accept a new operation, giving a WIDTH+1 period.
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            aShift_q <= a;
            bShift_q <= b;
            borrow_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign borrow_out = borrowOut_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level operation model plus
// directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             zero;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // Operation model: age counts edges since acceptance (-1 when idle).
  // Busy for ages 0..WIDTH-1, done at age WIDTH, next accept possible at the
  // edge after done; outputs take (a-b) mod 2^WIDTH and a<b when done appears.
  int               age = -1;
  logic [WIDTH-1:0] pendResult = '0;
  logic             pendBorrow = 1'b0;
  logic [WIDTH-1:0] expResult = '0;
  logic             expBorrow = 1'b0;
  logic             expZero = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      age       <= -1;
      expResult <= '0;
      expBorrow <= 1'b0;
      expZero   <= 1'b0;
    end else if (age == -1 || age == WIDTH) begin
      if (start) begin
        pendResult <= a - b;
        pendBorrow <= (a < b);
        age        <= 0;
      end else begin
        age <= -1;
      end
    end else begin
      age <= age + 1;
      if (age == WIDTH - 1) begin
        expResult <= pendResult;
        expBorrow <= pendBorrow;
        expZero   <= (pendResult == '0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.busy", {31'd0, busy}, {31'd0, (age >= 0 && age < WIDTH)});
      checkOutput("model.done", {31'd0, done}, {31'd0, (age == WIDTH)});
      checkOutput("model.result", {24'd0, result}, {24'd0, expResult});
      checkOutput("model.borrow", {31'd0, borrow_out}, {31'd0, expBorrow});
      checkOutput("model.zero", {31'd0, zero}, {31'd0, expZero});
    end
  end

  // Launches one operation from IDLE and checks timing and literal results.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic [WIDTH-1:0] expR, input logic expB,
                               input logic expZ);
    int  cycles;
    int  busyCycles;
    bit  seen;
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busyCycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 30) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCycles++;
        @(negedge clk);
        cycles++;
      end
    end
    if (!seen) begin
      checkOutput("op.timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("op.latency", cycles, WIDTH);
      checkOutput("op.busyCycles", busyCycles, WIDTH);
      checkOutput("op.result", {24'd0, result}, {24'd0, expR});
      checkOutput("op.borrow", {31'd0, borrow_out}, {31'd0, expB});
      checkOutput("op.zero", {31'd0, zero}, {31'd0, expZ});
      @(negedge clk);
      checkOutput("op.donePulse", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] av, bv, diff;
    int  cycles;
    bit  sawDone;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.result", {24'd0, result}, 32'd0);
    checkOutput("reset.borrow", {31'd0, borrow_out}, 32'd0);
    checkOutput("reset.zero", {31'd0, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    applyStimulus(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'hFF, 8'd1, 1'b1, 1'b0);
    applyStimulus(8'hAA, 8'hAA, 8'd0, 1'b0, 1'b1);
    applyStimulus(8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFE, 8'h01, 1'b0, 1'b0);

    // Start held high; operands disturbed mid-run, restored before each accept.
    a = 8'd20;
    b = 8'd3;
    start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      cycles = 0;
      repeat (3) begin
        @(negedge clk);
        cycles++;
      end
      a = 8'd99;
      b = 8'd50;
      while (!done && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      checkOutput("cont.done", {31'd0, done}, 32'd1);
      if (op > 0) checkOutput("cont.period", cycles, WIDTH + 1);
      checkOutput("cont.result", {24'd0, result}, 32'd17);
      a = 8'd20;
      b = 8'd3;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort with reset sampled on the edge that would process bit 4.
    a = 8'd50;
    b = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort.busy", {31'd0, busy}, 32'd0);
    checkOutput("abort.done", {31'd0, done}, 32'd0);
    checkOutput("abort.result", {24'd0, result}, 32'd0);
    checkOutput("abort.borrow", {31'd0, borrow_out}, 32'd0);
    checkOutput("abort.zero", {31'd0, zero}, 32'd0);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort.noDone", {31'd0, sawDone}, 32'd0);
    applyStimulus(8'd50, 8'd8, 8'd42, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      av = WIDTH'($urandom_range(0, 255));
      bv = WIDTH'($urandom_range(0, 255));
      if (i % 16 == 0) bv = av;
      diff = av - bv;
      applyStimulus(av, bv, diff, (av < bv), (diff == '0));
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
